// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit: RV32I memory-access stage. Runs one handshaked word-port
// transaction per start and drives register-file write-back for loads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd,
   output logic        busy,
   output logic        done,
   output logic [1:0]  fault_code,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [4:0]  wb_dest_reg,
   output logic [31:0] wb_data,
   output logic        wb_en
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic [15:0] cnt, cnt_nx;
   logic        op_load, op_load_nx;
   logic [2:0]  op_f3, op_f3_nx;
   logic [1:0]  op_off, op_off_nx;

   logic        mem_req_nx, mem_we_nx, wb_en_nx;
   logic [31:0] mem_addr_nx, mem_wdata_nx, wb_data_nx;
   logic [3:0]  mem_wstrb_nx;
   logic [4:0]  wb_dest_nx;
   logic [1:0]  fault_nx;

   logic        legal, misaligned, expired;
   logic [16:0] cnt_inc;
   logic [3:0]  strb;
   logic [31:0] lanes, ext;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Decode of the incoming request: legality, alignment, lane strobes/data
   always_comb begin
      legal = 1'b0;
      if (is_load && !is_store)
         legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
      else if (is_store && !is_load)
         legal = !funct3[2] && (funct3[1:0] != 2'd3);
      misaligned = ((funct3[1:0] == 2'd1) && addr[0]) ||
                   ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
      case (funct3[1:0])
         2'd0: begin
            strb  = 4'b0001 << addr[1:0];
            lanes = {4{store_data[7:0]}};
         end
         2'd1: begin
            strb  = 4'b0011 << {addr[1], 1'b0};
            lanes = {2{store_data[15:0]}};
         end
         default: begin
            strb  = 4'b1111;
            lanes = store_data;
         end
      endcase
   end

   always_comb begin
      ld_byte = mem_rdata[{op_off, 3'b000} +: 8];
      ld_half = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (op_f3)
         3'd0:    ext = {{24{ld_byte[7]}}, ld_byte};
         3'd1:    ext = {{16{ld_half[15]}}, ld_half};
         3'd4:    ext = {24'd0, ld_byte};
         3'd5:    ext = {16'd0, ld_half};
         default: ext = mem_rdata;
      endcase
      cnt_inc = {1'b0, cnt} + 17'd1;
      expired = (cnt_inc >= 17'(TIMEOUT_CYCLES));
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt_inc[15:0];
      op_load_nx   = op_load;
      op_f3_nx     = op_f3;
      op_off_nx    = op_off;
      mem_req_nx   = mem_req;
      mem_we_nx    = mem_we;
      mem_addr_nx  = mem_addr;
      mem_wstrb_nx = mem_wstrb;
      mem_wdata_nx = mem_wdata;
      wb_dest_nx   = wb_dest_reg;
      wb_data_nx   = 32'd0;
      wb_en_nx     = 1'b0;
      fault_nx     = 2'd0;
      case (state)
         IDLE: begin
            cnt_nx = 16'd0;
            if (start) begin
               wb_dest_nx = rd;
               if (!legal) begin
                  state_nx = DONE;
                  fault_nx = 2'd2;
               end else if (misaligned) begin
                  state_nx = DONE;
                  fault_nx = 2'd1;
               end else begin
                  state_nx     = REQ;
                  op_load_nx   = is_load;
                  op_f3_nx     = funct3;
                  op_off_nx    = addr[1:0];
                  mem_req_nx   = 1'b1;
                  mem_we_nx    = is_store;
                  mem_addr_nx  = {addr[31:2], 2'b00};
                  mem_wstrb_nx = is_store ? strb : 4'b0000;
                  mem_wdata_nx = is_store ? lanes : 32'd0;
               end
            end
         end
         REQ: begin
            // A grant on the expiry edge takes priority over the abort
            if (mem_gnt) begin
               mem_req_nx = 1'b0;
               cnt_nx     = 16'd0;
               state_nx   = op_load ? WAIT_R : DONE;
            end else if (expired) begin
               mem_req_nx = 1'b0;
               state_nx   = DONE;
               fault_nx   = 2'd3;
            end
         end
         WAIT_R: begin
            if (mem_rvalid) begin
               state_nx   = DONE;
               wb_data_nx = ext;
               wb_en_nx   = (wb_dest_reg != 5'd0);
            end else if (expired) begin
               state_nx = DONE;
               fault_nx = 2'd3;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 16'd0;
         op_load     <= 1'b0;
         op_f3       <= 3'd0;
         op_off      <= 2'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fault_code  <= 2'd0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 32'd0;
         mem_wstrb   <= 4'd0;
         mem_wdata   <= 32'd0;
         wb_dest_reg <= 5'd0;
         wb_data     <= 32'd0;
         wb_en       <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         op_load     <= op_load_nx;
         op_f3       <= op_f3_nx;
         op_off      <= op_off_nx;
         busy        <= (state_nx != IDLE);
         done        <= (state_nx == DONE);
         fault_code  <= fault_nx;
         mem_req     <= mem_req_nx;
         mem_we      <= mem_we_nx;
         mem_addr    <= mem_addr_nx;
         mem_wstrb   <= mem_wstrb_nx;
         mem_wdata   <= mem_wdata_nx;
         wb_dest_reg <= wb_dest_nx;
         wb_data     <= wb_data_nx;
         wb_en       <= wb_en_nx;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit: scoreboard bench for load_store_unit with a byte-level
// reference model and randomized memory-side timing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, is_load = 1'b0, is_store = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = 32'd0, store_data = 32'd0;
   logic [4:0]  rd = 5'd0;
   logic        busy, done, mem_req, mem_we, wb_en;
   logic [1:0]  fault_code;
   logic [31:0] mem_addr, mem_wdata, wb_data;
   logic [3:0]  mem_wstrb;
   logic [4:0]  wb_dest_reg;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load),
      .is_store(is_store), .funct3(funct3), .addr(addr),
      .store_data(store_data), .rd(rd), .busy(busy), .done(done),
      .fault_code(fault_code), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_dest_reg(wb_dest_reg), .wb_data(wb_data), .wb_en(wb_en)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [1:0]  fault;
      logic        wen;
      logic [4:0]  dest;
      logic [31:0] data;
      int          at_cyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] wd;
   } req_t;

   exp_t exp_q[$];
   req_t req_q[$];
   int   pass_cnt = 0;
   int   tot_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      tot_cnt++;
      if (act === expv) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
   endtask

   // Completion monitor: every done pulse must match the oldest expectation
   always @(negedge clk) begin
      if (done) begin
         tot_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL done_unexpected: got done=1 expected no completion (t=%0t)", $time);
         end else begin
            exp_t e;
            pass_cnt++;
            e = exp_q.pop_front();
            chk("fault_code", fault_code, e.fault);
            chk("wb_en", wb_en, e.wen);
            chk("wb_dest_reg", wb_dest_reg, e.dest);
            chk("wb_data", wb_data, e.data);
            chk("done_cycle", cyc, e.at_cyc);
            chk("busy_at_done", busy, 1);
         end
      end
   end

   // Request monitor: the request must stay stable for as long as mem_req is high
   logic prev_req = 1'b0;
   always @(negedge clk) begin
      if (mem_req === 1'b1) begin
         tot_cnt++;
         if (req_q.size() == 0) begin
            $display("FAIL req_unexpected: got mem_req=1 expected 0 (t=%0t)", $time);
         end else begin
            pass_cnt++;
            chk("mem_addr", mem_addr, req_q[0].a);
            chk("mem_we", mem_we, req_q[0].we);
            chk("mem_wstrb", mem_wstrb, req_q[0].strb);
            if (req_q[0].we) chk("mem_wdata", mem_wdata, req_q[0].wd);
         end
      end
      if (prev_req && (mem_req !== 1'b1) && req_q.size() > 0) void'(req_q.pop_front());
      prev_req = (mem_req === 1'b1);
   end

   task automatic do_txn(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                         input int gd, input int rvd, input logic [31:0] rdat, input bit poke);
      exp_t   e;
      req_t   q;
      bit     legal, mis;
      int     size, off, lat;
      longint v;
      legal = (ld != st) && (ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                                : (f3 inside {3'd0, 3'd1, 3'd2}));
      size  = 1 << (int'(f3) % 4);
      off   = int'(a % 32'd4);
      mis   = legal && ((off % size) != 0);
      e.dest = r; e.wen = 1'b0; e.data = 32'd0;
      if (!legal)         begin e.fault = 2'd2; lat = 0; end
      else if (mis)       begin e.fault = 2'd1; lat = 0; end
      else if (gd >= TO)  begin e.fault = 2'd3; lat = TO; end
      else if (st)        begin e.fault = 2'd0; lat = gd + 1; end
      else if (rvd >= TO) begin e.fault = 2'd3; lat = gd + 1 + TO; end
      else begin
         e.fault = 2'd0;
         lat = gd + rvd + 2;
         v = 0;
         for (int i = 0; i < size; i++)
            v += ((longint'(rdat) >> (8 * (off + i))) & 255) << (8 * i);
         if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v -= (longint'(1) << (8 * size));
         e.data = v[31:0];
         e.wen  = (r != 5'd0);
      end
      q.a = a - (a % 32'd4);
      q.we = st;
      q.strb = st ? 4'(((1 << size) - 1) << off) : 4'd0;
      q.wd = 32'd0;
      for (int j = 0; j < 4; j++)
         q.wd |= ((sd >> (8 * (j % size))) & 32'hFF) << (8 * j);

      @(negedge clk);
      chk("idle_busy", busy, 0);
      e.at_cyc = cyc + 1 + lat;
      exp_q.push_back(e);
      if (legal && !mis) req_q.push_back(q);
      start = 1'b1; is_load = ld; is_store = st; funct3 = f3;
      addr = a; store_data = sd; rd = r;
      @(negedge clk);
      start = 1'b0; is_load = 1'($urandom); is_store = 1'($urandom);
      funct3 = 3'($urandom); addr = $urandom; store_data = $urandom; rd = 5'($urandom);
      if (legal && !mis) begin
         for (int k = 0; k < ((gd < TO) ? gd : TO); k++) begin
            mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            @(negedge clk);
         end
         mem_rvalid = 1'b0;
         if (gd < TO) begin
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            if (ld) begin
               for (int k = 0; k < ((rvd < TO) ? rvd : TO); k++) begin
                  if (poke) start = 1'b1;
                  @(negedge clk);
               end
               start = 1'b0;
               if (rvd < TO) begin
                  mem_rvalid = 1'b1; mem_rdata = rdat;
                  @(negedge clk);
                  mem_rvalid = 1'b0; mem_rdata = $urandom;
               end
            end
         end
      end
      for (int k = 0; k < 20 && busy; k++) @(negedge clk);
      chk("drain_busy", busy, 0);
   endtask

   task automatic reset_mid_load();
      req_t q;
      q.a = 32'h400; q.we = 1'b0; q.strb = 4'd0; q.wd = 32'd0;
      @(negedge clk);
      req_q.push_back(q);
      start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2;
      addr = 32'h400; rd = 5'd7;
      @(negedge clk);
      start = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("busy_in_wait_r", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_ctrl", {busy, done, fault_code, mem_req, mem_we, mem_wstrb, wb_en, wb_dest_reg}, 0);
      chk("rst_mem", {mem_addr, mem_wdata}, 0);
      chk("rst_wb_data", wb_data, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic ld, st;
      repeat (2) @(negedge clk);
      chk("reset_ctrl", {busy, done, fault_code, mem_req, mem_we, mem_wstrb, wb_en, wb_dest_reg}, 0);
      chk("reset_data", {mem_addr, mem_wdata}, 0);
      chk("reset_wb_data", wb_data, 0);
      rst_n = 1'b1;

      do_txn(1, 0, 3'd2, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF, 0);
      do_txn(1, 0, 3'd0, 32'h103, 32'h0, 5'd3, 0, 0, 32'h80ABCDEF, 0);
      do_txn(1, 0, 3'd4, 32'h103, 32'h0, 5'd3, 0, 0, 32'h80ABCDEF, 0);
      do_txn(1, 0, 3'd1, 32'h102, 32'h0, 5'd3, 0, 0, 32'h80ABCDEF, 0);
      do_txn(0, 1, 3'd0, 32'h201, 32'h12345678, 5'd9, 3, 0, 32'h0, 0);
      do_txn(0, 1, 3'd2, 32'h302, 32'h11111111, 5'd1, 0, 0, 32'h0, 0);
      do_txn(1, 0, 3'd1, 32'h101, 32'h0, 5'd2, 0, 0, 32'h0, 0);
      do_txn(1, 0, 3'd3, 32'h100, 32'h0, 5'd2, 0, 0, 32'h0, 0);
      do_txn(1, 1, 3'd2, 32'h100, 32'h0, 5'd2, 0, 0, 32'h0, 0);
      do_txn(1, 0, 3'd2, 32'h500, 32'h0, 5'd4, TO, 0, 32'h0, 0);
      do_txn(1, 0, 3'd2, 32'h504, 32'h0, 5'd4, TO - 1, 0, 32'hCAFEF00D, 0);
      do_txn(1, 0, 3'd2, 32'h508, 32'h0, 5'd4, 0, TO, 32'h0, 0);
      do_txn(1, 0, 3'd2, 32'h50C, 32'h0, 5'd0, 0, 0, 32'h12345678, 0);
      do_txn(1, 0, 3'd2, 32'h600, 32'h0, 5'd10, 1, 3, 32'hA5A55A5A, 1);
      reset_mid_load();
      do_txn(1, 0, 3'd2, 32'h700, 32'h0, 5'd11, 0, 0, 32'h0BADC0DE, 0);

      for (int n = 0; n < 150; n++) begin
         if ($urandom % 10 == 0) begin
            ld = 1'($urandom); st = ld;
         end else begin
            ld = 1'($urandom); st = !ld;
         end
         do_txn(ld, st, 3'($urandom), $urandom, $urandom, 5'($urandom),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), $urandom,
                ($urandom % 4) == 0);
      end

      repeat (3) @(negedge clk);
      chk("exp_q_empty", exp_q.size(), 0);
      chk("req_q_empty", req_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

`default_nettype wire
